id_stage_pipe: RTL and testbench

//  Parametrised decode stage with its own ID/EX pipeline register, replacing the combinational decoder plus external pipe reg.

---
 rtl/id_stage_pipe.sv | 188 ++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// Decode stage with its own ID/EX register: ARM-subset decode, condition check, 16-entry regfile
// read, bubble/flush handling and a post-branch squash window.
module id_stage_pipe #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned BRANCH_SHADOW = 1,
    parameter bit          BYPASS_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    input  logic [3:0]        status,
    input  logic              hazard,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              two_src,
    output logic              ex_valid,
    output logic              ex_wb_en,
    output logic              ex_mem_r_en,
    output logic              ex_mem_w_en,
    output logic              ex_b,
    output logic              ex_s,
    output logic              ex_imm,
    output logic [3:0]        ex_exe_cmd,
    output logic [DATA_W-1:0] ex_val_rn,
    output logic [DATA_W-1:0] ex_val_rm,
    output logic [11:0]       ex_shift_operand,
    output logic [23:0]       ex_signed_imm_24,
    output logic [3:0]        ex_dest,
    output logic [3:0]        ex_src1,
    output logic [3:0]        ex_src2,
    output logic              shadow_busy
);

    localparam logic [2:0] ShadowInit = 3'(BRANCH_SHADOW);

    logic [1:0]        mode;
    logic [3:0]        op;
    logic              s_bit, store;
    logic              dec_nop, dec_wb, dec_mem_r, dec_mem_w, dec_b, dec_s, dec_imm;
    logic [3:0]        dec_cmd;
    logic              cond_pass, kill;
    logic              flag_n, flag_z, flag_c, flag_v;
    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rd_rn, rd_rm;
    logic [2:0]        squash_q, squash_d;

    assign mode    = instr[27:26];
    assign op      = instr[24:21];
    assign s_bit   = instr[20];
    assign store   = (mode == 2'b01) & ~s_bit;
    assign src1    = instr[19:16];
    assign src2    = store ? instr[15:12] : instr[3:0];
    assign two_src = ~instr[25] | store;

    always_comb begin
        dec_nop   = 1'b0;
        dec_wb    = 1'b0;
        dec_mem_r = 1'b0;
        dec_mem_w = 1'b0;
        dec_b     = 1'b0;
        dec_s     = 1'b0;
        dec_cmd   = 4'b0000;
        unique case (mode)
            2'b00: begin
                dec_wb = 1'b1;
                dec_s  = s_bit;
                unique case (op)
                    4'b1101: dec_cmd = 4'b0001;
                    4'b1111: dec_cmd = 4'b1001;
                    4'b0100: dec_cmd = 4'b0010;
                    4'b0101: dec_cmd = 4'b0011;
                    4'b0010: dec_cmd = 4'b0100;
                    4'b0110: dec_cmd = 4'b0101;
                    4'b0000: dec_cmd = 4'b0110;
                    4'b1100: dec_cmd = 4'b0111;
                    4'b0001: dec_cmd = 4'b1000;
                    4'b1010: begin dec_cmd = 4'b0100; dec_wb = 1'b0; end
                    4'b1000: begin dec_cmd = 4'b0110; dec_wb = 1'b0; end
                    default: begin dec_nop = 1'b1; dec_wb = 1'b0; dec_s = 1'b0; end
                endcase
            end
            2'b01: begin
                dec_cmd   = 4'b0010;
                dec_mem_r = s_bit;
                dec_wb    = s_bit;
                dec_mem_w = ~s_bit;
            end
            2'b10:   dec_b = 1'b1;
            default: dec_nop = 1'b1;
        endcase
        dec_imm = instr[25] & ~dec_nop;
    end

    assign {flag_n, flag_z, flag_c, flag_v} = status;

    always_comb begin
        cond_pass = 1'b0;
        unique case (instr[31:28])
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Write-through lets an instruction see a result retiring in the same cycle.
    assign rd_rn = (BYPASS_EN && wb_en && (wb_dest == src1)) ? wb_value : rf_q[src1];
    assign rd_rm = (BYPASS_EN && wb_en && (wb_dest == src2)) ? wb_value : rf_q[src2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else if (wb_en) begin
            rf_q[wb_dest] <= wb_value;
        end
    end

    assign shadow_busy = (squash_q != 3'd0);
    assign kill        = flush | hazard | ~instr_valid | ~cond_pass | shadow_busy;

    // Stalled cycles re-present the same slot, so they do not consume the shadow.
    always_comb begin
        squash_d = squash_q;
        if (flush) begin
            squash_d = 3'd0;
        end else if (~kill & dec_b) begin
            squash_d = ShadowInit;
        end else if (shadow_busy && !hazard && instr_valid) begin
            squash_d = squash_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            squash_q         <= 3'd0;
            ex_valid         <= 1'b0;
            ex_wb_en         <= 1'b0;
            ex_mem_r_en      <= 1'b0;
            ex_mem_w_en      <= 1'b0;
            ex_b             <= 1'b0;
            ex_s             <= 1'b0;
            ex_imm           <= 1'b0;
            ex_exe_cmd       <= 4'b0000;
            ex_val_rn        <= '0;
            ex_val_rm        <= '0;
            ex_shift_operand <= 12'd0;
            ex_signed_imm_24 <= 24'd0;
            ex_dest          <= 4'd0;
            ex_src1          <= 4'd0;
            ex_src2          <= 4'd0;
        end else begin
            squash_q         <= squash_d;
            ex_valid         <= ~kill;
            ex_wb_en         <= ~kill & dec_wb;
            ex_mem_r_en      <= ~kill & dec_mem_r;
            ex_mem_w_en      <= ~kill & dec_mem_w;
            ex_b             <= ~kill & dec_b;
            ex_s             <= ~kill & dec_s;
            ex_imm           <= ~kill & dec_imm;
            ex_exe_cmd       <= kill ? 4'b0000 : dec_cmd;
            ex_val_rn        <= rd_rn;
            ex_val_rm        <= rd_rm;
            ex_shift_operand <= instr[11:0];
            ex_signed_imm_24 <= instr[23:0];
            ex_dest          <= instr[15:12];
            ex_src1          <= src1;
            ex_src2          <= src2;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two instances (bypass/shadow 1, no-bypass/shadow 3) against a
// reference model, plus a decode vector table and directed multi-cycle sequences.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, hazard, flush, wb_en;
    logic [31:0] instr, wb_value;
    logic [3:0]  status, wb_dest;

    logic [3:0]  a_src1, a_src2, b_src1, b_src2;
    logic        a_two_src, b_two_src;
    logic        a_ex_valid, a_ex_wb_en, a_ex_mem_r_en, a_ex_mem_w_en, a_ex_b, a_ex_s, a_ex_imm;
    logic        b_ex_valid, b_ex_wb_en, b_ex_mem_r_en, b_ex_mem_w_en, b_ex_b, b_ex_s, b_ex_imm;
    logic [3:0]  a_ex_exe_cmd, a_ex_dest, a_ex_src1, a_ex_src2;
    logic [3:0]  b_ex_exe_cmd, b_ex_dest, b_ex_src1, b_ex_src2;
    logic [31:0] a_ex_val_rn, a_ex_val_rm, b_ex_val_rn, b_ex_val_rm;
    logic [11:0] a_ex_shift_operand, b_ex_shift_operand;
    logic [23:0] a_ex_signed_imm_24, b_ex_signed_imm_24;
    logic        a_shadow_busy, b_shadow_busy;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .BRANCH_SHADOW(1), .BYPASS_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .status(status),
        .hazard(hazard), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(a_src1), .src2(a_src2), .two_src(a_two_src), .ex_valid(a_ex_valid),
        .ex_wb_en(a_ex_wb_en), .ex_mem_r_en(a_ex_mem_r_en), .ex_mem_w_en(a_ex_mem_w_en),
        .ex_b(a_ex_b), .ex_s(a_ex_s), .ex_imm(a_ex_imm), .ex_exe_cmd(a_ex_exe_cmd),
        .ex_val_rn(a_ex_val_rn), .ex_val_rm(a_ex_val_rm), .ex_shift_operand(a_ex_shift_operand),
        .ex_signed_imm_24(a_ex_signed_imm_24), .ex_dest(a_ex_dest), .ex_src1(a_ex_src1),
        .ex_src2(a_ex_src2), .shadow_busy(a_shadow_busy)
    );

    id_stage_pipe #(.DATA_W(32), .BRANCH_SHADOW(3), .BYPASS_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .status(status),
        .hazard(hazard), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(b_src1), .src2(b_src2), .two_src(b_two_src), .ex_valid(b_ex_valid),
        .ex_wb_en(b_ex_wb_en), .ex_mem_r_en(b_ex_mem_r_en), .ex_mem_w_en(b_ex_mem_w_en),
        .ex_b(b_ex_b), .ex_s(b_ex_s), .ex_imm(b_ex_imm), .ex_exe_cmd(b_ex_exe_cmd),
        .ex_val_rn(b_ex_val_rn), .ex_val_rm(b_ex_val_rm), .ex_shift_operand(b_ex_shift_operand),
        .ex_signed_imm_24(b_ex_signed_imm_24), .ex_dest(b_ex_dest), .ex_src1(b_ex_src1),
        .ex_src2(b_ex_src2), .shadow_busy(b_shadow_busy)
    );

    logic [123:0] act_a, act_b;
    assign act_a = {a_ex_valid, a_ex_wb_en, a_ex_mem_r_en, a_ex_mem_w_en, a_ex_b, a_ex_s, a_ex_imm,
                    a_ex_exe_cmd, a_ex_val_rn, a_ex_val_rm, a_ex_shift_operand,
                    a_ex_signed_imm_24, a_ex_dest, a_ex_src1, a_ex_src2, a_shadow_busy};
    assign act_b = {b_ex_valid, b_ex_wb_en, b_ex_mem_r_en, b_ex_mem_w_en, b_ex_b, b_ex_s, b_ex_imm,
                    b_ex_exe_cmd, b_ex_val_rn, b_ex_val_rm, b_ex_shift_operand,
                    b_ex_signed_imm_24, b_ex_dest, b_ex_src1, b_ex_src2, b_shadow_busy};

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: ALU command per data-processing opcode, -1 = undefined (NOP).
    int           cmd_of_op [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
    int           m_shadow  [2]  = '{1, 3};
    bit           m_byp     [2]  = '{1'b1, 1'b0};
    logic [31:0]  m_rf      [2][16];
    int           m_cnt     [2];
    logic [123:0] m_ex      [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 16; r++) m_rf[k][r] = 32'd0;
            m_cnt[k] = 0;
            m_ex[k]  = '0;
        end
    endtask

    // ARM conditions come in pairs; the low bit inverts the base test (except 1111 = never).
    function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] st);
        bit n, z, c, v, base;
        {n, z, c, v} = st;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return cond[0] == 1'b0;
        endcase
        return cond[0] ? !base : base;
    endfunction

    function automatic logic [8:0] model_src();
        bit store;
        store = (instr[27:26] == 2'b01) && !instr[20];
        return {instr[19:16], store ? instr[15:12] : instr[3:0], !instr[25] || store};
    endfunction

    task automatic model_edge();
        logic [1:0]  mode;
        logic [3:0]  op, cmd, s1, s2;
        logic [31:0] rn, rm;
        bit          nop, wb, mr, mw, br, sf, im, kill, v, busy;
        int          c;
        mode = instr[27:26];
        op   = instr[24:21];
        {s1, s2} = model_src() >> 1;
        nop = 0; wb = 0; mr = 0; mw = 0; br = 0; sf = 0; cmd = 4'd0;
        case (mode)
            2'b00: begin
                c = cmd_of_op[op];
                if (c < 0) nop = 1;
                else begin
                    cmd = 4'(c);
                    wb  = (op != 4'b1010) && (op != 4'b1000);
                    sf  = instr[20];
                end
            end
            2'b01: begin cmd = 4'b0010; mr = instr[20]; wb = instr[20]; mw = !instr[20]; end
            2'b10: br = 1;
            default: nop = 1;
        endcase
        im = instr[25] && !nop;
        for (int k = 0; k < 2; k++) begin
            kill = flush || hazard || !instr_valid || !cond_ok(instr[31:28], status) || m_cnt[k] > 0;
            v    = !kill;
            rn   = (m_byp[k] && wb_en && wb_dest == s1) ? wb_value : m_rf[k][s1];
            rm   = (m_byp[k] && wb_en && wb_dest == s2) ? wb_value : m_rf[k][s2];
            if (flush) m_cnt[k] = 0;
            else if (v && br) m_cnt[k] = m_shadow[k];
            else if (m_cnt[k] > 0 && !hazard && instr_valid) m_cnt[k]--;
            busy = m_cnt[k] > 0;
            m_ex[k] = {v, wb && v, mr && v, mw && v, br && v, sf && v, im && v, v ? cmd : 4'd0,
                       rn, rm, instr[11:0], instr[23:0], instr[15:12], s1, s2, busy};
            if (wb_en) m_rf[k][wb_dest] = wb_value;
        end
    endtask

    // Inputs must already be set; checks comb outputs, clocks once, checks the EX slot.
    task automatic step();
        #1;
        check("comb_a", {a_src1, a_src2, a_two_src}, model_src());
        check("comb_b", {b_src1, b_src2, b_two_src}, model_src());
        model_edge();
        @(posedge clk);
        #1;
        check("ex_a", act_a, m_ex[0]);
        check("ex_b", act_b, m_ex[1]);
    endtask

    task automatic drive(input logic [31:0] i, input logic iv, input logic hz, input logic fl);
        instr = i; instr_valid = iv; hazard = hz; flush = fl;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  status;
        logic        hazard;
        logic        iv;
        logic [6:0]  ectl;  // {valid, wb, mem_r, mem_w, b, s, imm}
        logic [3:0]  ecmd;
    } vec_t;

    vec_t vecs [19];

    initial begin
        vecs[0]  = '{32'hE1A01002, 4'h0, 1'b0, 1'b1, 7'b1100000, 4'b0001};  // MOV
        vecs[1]  = '{32'hE0813002, 4'h0, 1'b0, 1'b1, 7'b1100000, 4'b0010};  // ADD
        vecs[2]  = '{32'hE2913005, 4'h0, 1'b0, 1'b1, 7'b1100011, 4'b0010};  // ADDS imm
        vecs[3]  = '{32'hE1510002, 4'h0, 1'b0, 1'b1, 7'b1000010, 4'b0100};  // CMP
        vecs[4]  = '{32'hE5912000, 4'h0, 1'b0, 1'b1, 7'b1110000, 4'b0010};  // LDR
        vecs[5]  = '{32'hE5812000, 4'h0, 1'b0, 1'b1, 7'b1001000, 4'b0010};  // STR
        vecs[6]  = '{32'hEA000004, 4'h0, 1'b0, 1'b1, 7'b1000101, 4'b0000};  // B
        vecs[7]  = '{32'hE1700000, 4'h0, 1'b0, 1'b1, 7'b1000000, 4'b0000};  // undefined op
        vecs[8]  = '{32'hEE000000, 4'h0, 1'b0, 1'b1, 7'b1000000, 4'b0000};  // mode 11
        vecs[9]  = '{32'h00813002, 4'h0, 1'b0, 1'b1, 7'b0000000, 4'b0000};  // ADDEQ, Z=0
        vecs[10] = '{32'h00813002, 4'h4, 1'b0, 1'b1, 7'b1100000, 4'b0010};  // ADDEQ, Z=1
        vecs[11] = '{32'hF0813002, 4'hF, 1'b0, 1'b1, 7'b0000000, 4'b0000};  // never
        vecs[12] = '{32'hC0813002, 4'h9, 1'b0, 1'b1, 7'b1100000, 4'b0010};  // GT, N=V=1
        vecs[13] = '{32'hB0813002, 4'h8, 1'b0, 1'b1, 7'b1100000, 4'b0010};  // LT, N!=V
        vecs[14] = '{32'hE1A01002, 4'h0, 1'b1, 1'b1, 7'b0000000, 4'b0000};  // hazard
        vecs[15] = '{32'hE1A01002, 4'h0, 1'b0, 1'b0, 7'b0000000, 4'b0000};  // not valid
        vecs[16] = '{32'hE1E00000, 4'h0, 1'b0, 1'b1, 7'b1100000, 4'b1001};  // MVN
        vecs[17] = '{32'hE0C00000, 4'h0, 1'b0, 1'b1, 7'b1100000, 4'b0101};  // SBC
        vecs[18] = '{32'hE1100000, 4'h0, 1'b0, 1'b1, 7'b1000010, 4'b0110};  // TST

        rst = 1'b0;
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        status = 4'h0; wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'd0;
        model_reset();
        #12;
        check("reset_a", act_a, 124'd0);
        check("reset_b", act_b, 124'd0);
        #3 rst = 1'b1;

        // Decode table; a flush cycle after each vector closes any branch shadow.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].instr, vecs[i].iv, vecs[i].hazard, 1'b0);
            status = vecs[i].status;
            step();
            check($sformatf("vec%0d_ctl", i), act_a[123:113], {vecs[i].ectl, vecs[i].ecmd});
            drive(32'd0, 1'b0, 1'b0, 1'b1);
            step();
        end
        status = 4'h0;
        flush  = 1'b0;

        // Regfile write then ADD R3,R1,R2.
        wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'd5; step();
        wb_dest = 4'd2; wb_value = 32'd7; step();
        wb_en = 1'b0; drive(32'hE0813002, 1'b1, 1'b0, 1'b0); step();
        check("add_rn_rm", {a_ex_val_rn, a_ex_val_rm}, {32'd5, 32'd7});
        check("add_ctl", {a_ex_valid, a_ex_wb_en, a_ex_exe_cmd, a_ex_dest}, {2'b11, 4'b0010, 4'd3});

        // Hazard bubble, then the same MOV issues.
        drive(32'hE1A01002, 1'b1, 1'b1, 1'b0); step();
        check("haz_bubble", a_ex_valid, 1'b0);
        hazard = 1'b0; step();
        check("haz_issue", {a_ex_valid, a_ex_exe_cmd}, {1'b1, 4'b0001});

        // Same-cycle writeback to R4 while STR reads R4 as src2.
        wb_en = 1'b1; wb_dest = 4'd4; wb_value = 32'h1111; drive(32'd0, 1'b0, 1'b0, 1'b0); step();
        wb_value = 32'hDEAD; drive(32'hE5814000, 1'b1, 1'b0, 1'b0);
        #1 check("str_two_src", {a_two_src, a_src2}, {1'b1, 4'd4});
        step();
        wb_en = 1'b0;
        check("bypass_on", a_ex_val_rm, 32'hDEAD);
        check("bypass_off", b_ex_val_rm, 32'h1111);
        check("str_mem_w", a_ex_mem_w_en, 1'b1);

        // Branch shadow; a hazard cycle inside the window must not consume it.
        drive(32'hEA000004, 1'b1, 1'b0, 1'b0); step();
        check("br_busy", {a_ex_b, a_shadow_busy}, 2'b11);
        drive(32'hE0813002, 1'b1, 1'b1, 1'b0); step();
        check("br_haz_hold", a_shadow_busy, 1'b1);
        hazard = 1'b0; step();
        check("br_squash", {a_ex_valid, a_shadow_busy}, 2'b00);
        step();
        check("br_after", a_ex_valid, 1'b1);

        // Flush together with hazard inside a shadow window.
        drive(32'hEA000004, 1'b1, 1'b0, 1'b0); step();
        drive(32'hE0813002, 1'b1, 1'b1, 1'b1); step();
        check("flush_haz", {a_ex_valid, a_shadow_busy, b_shadow_busy}, 3'b000);

        // Asynchronous reset mid-stream.
        drive(32'hE0813002, 1'b1, 1'b0, 1'b0); step();
        #2 rst = 1'b0;
        #1;
        check("async_rst_a", act_a, 124'd0);
        check("async_rst_b", act_b, 124'd0);
        model_reset();
        #2 rst = 1'b1;
        step();

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            instr = $urandom;
            if ($urandom_range(3) != 0) instr[31:28] = 4'hE;
            instr_valid = ($urandom_range(9) != 0);
            hazard      = ($urandom_range(6) == 0);
            flush       = ($urandom_range(9) == 0);
            status      = 4'($urandom);
            wb_en       = $urandom_range(1) == 1;
            wb_dest     = 4'($urandom);
            wb_value    = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
